// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-bit unsigned restoring sequential divider, one quotient bit per cycle
// Includes the 32-bit unsigned magnitude comparator used for the trial decision.

module cmp_u32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_l
);
    assign a_l = (a < b);
endmodule

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_lt;
    logic             w_qbit;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rnew;
    logic [WIDTH-1:0] w_qnew;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == 5'd31);

    // r_dvd shifts out dividend bits at the top and collects quotient bits at the bottom
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};

    cmp_u32 u_cmp (
        .a   (w_trial[WIDTH-1:0]),
        .b   (r_dvs),
        .a_l (w_lt)
    );

    assign w_qbit = w_trial[WIDTH] | ~w_lt;
    assign w_rnew = w_qbit ? (w_trial[WIDTH-1:0] - r_dvs) : w_trial[WIDTH-1:0];
    assign w_qnew = {r_dvd[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Visible results are written only when DONE is entered, so partial state never leaks out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= dividend;
            r_dvs <= divisor;
            if (divisor == '0) begin
                r_quot <= '1;
                r_remo <= dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            r_rem <= w_rnew;
            r_dvd <= w_qnew;
            if (w_last) begin
                r_quot <= w_qnew;
                r_remo <= w_rnew;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against a cycle-level arithmetic model

module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_left counts edges until the result appears; results come from / and %
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] p_q = '0, p_r = '0;
    logic        p_z = 1'b0;
    logic [31:0] h_q = '0, h_r = '0;
    logic        h_z = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            h_q = '0; h_r = '0; h_z = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    h_q = p_q; h_r = p_r; h_z = p_z;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    p_q = 32'hFFFF_FFFF; p_r = dividend; p_z = 1'b1;
                    m_done = 1'b1;
                    h_q = p_q; h_r = p_r; h_z = p_z;
                end else begin
                    p_q = dividend / divisor; p_r = dividend % divisor; p_z = 1'b0;
                    m_left = 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        {31'b0, busy},        {31'b0, (m_left > 0)});
            chk("done",        {31'b0, done},        {31'b0, m_done});
            chk("quotient",    quotient,             h_q);
            chk("remainder",   remainder,            h_r);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, h_z});
        end
    end

    // Called at a negedge; returns at the negedge where done is seen (or after the bound)
    task automatic launch(input logic [31:0] a, input logic [31:0] b, output int n, output int nb);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
    endtask

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic z,
                       input int lat, input int nbusy);
        int n, nb;
        launch(a, b, n, nb);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_cycles"}, nb, nbusy);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, z});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        dir("d100_7",   32'd100,         32'd7,           32'd14,          32'd2,           1'b0, 33, 32);
        @(negedge clk);
        dir("dmax_1",   32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0,           1'b0, 33, 32);
        dir("d33bit",   32'hFFFF_FFFF,   32'h8000_0001,   32'd1,           32'h7FFF_FFFE,   1'b0, 33, 32);
        @(negedge clk);
        dir("d7_100",   32'd7,           32'd100,         32'd0,           32'd7,           1'b0, 33, 32);
        dir("d5_0",     32'd5,           32'd0,           32'hFFFF_FFFF,   32'd5,           1'b1, 1,  0);
        @(negedge clk);

        // Mid-run start is ignored, then a reset aborts the division
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
        dir("d9_3",     32'd9,           32'd3,           32'd3,           32'd0,           1'b0, 33, 32);

        // Second start lands in the done cycle of the first
        @(negedge clk);
        dir("d20_6",    32'd20,          32'd6,           32'd3,           32'd2,           1'b0, 33, 32);
        dir("d21_5",    32'd21,          32'd5,           32'd4,           32'd1,           1'b0, 33, 32);

        repeat (4000) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 5) == 0);
            dividend = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            case ($urandom_range(0, 4))
                0:       divisor = 32'd0;
                1:       divisor = 32'($urandom_range(1, 15));
                2:       divisor = $urandom | 32'h8000_0000;
                default: divisor = $urandom;
            endcase
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
